// File: rtl/hski2c_byte_engine.sv
// Byte-level I2C master: executes START/STOP/WRITE/READ one command at a time,
// driving open-drain SCL/SDA through output enables, with clock stretching and arbitration detection.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | cmd_ready high, waiting for a command
// ST_START  | four quarters of a (repeated) START condition
// ST_STOP   | four quarters of a STOP condition
// ST_SLOT   | nine bit slots of a WRITE or READ, four quarters each
// ST_FINISH | publish results, pulse done, return to IDLE
module hski2c_byte_engine #(
    parameter int CLKDIV = 24,
    parameter int CNT_W  = 8
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_wdata,
    input  logic       cmd_ack,
    output logic       done,
    output logic [7:0] rdata,
    output logic       rx_nack,
    output logic       arb_lost,
    output logic       bus_busy,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_oe,
    output logic       sda_oe
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_STOP,
        ST_SLOT,
        ST_FINISH
    } state_t;

    localparam logic [1:0] OP_START = 2'd0;
    localparam logic [1:0] OP_STOP  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;
    localparam logic [1:0] OP_READ  = 2'd3;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLKDIV);

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_s;
    logic       sda_s;

    state_t           state;
    logic [1:0]       quarter;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       slot;
    logic [1:0]       op_q;
    logic [7:0]       wsh;
    logic [7:0]       rsh;
    logic             ack_q;
    logic             nack_q;
    logic             arb_q;

    // Idle bus reads high, so the synchronizers come out of reset released.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl_i};
            sda_sync <= {sda_sync[0], sda_i};
        end
    end

    assign scl_s = scl_sync[1];
    assign sda_s = sda_sync[1];

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= ST_IDLE;
            quarter   <= 2'd0;
            cnt       <= '0;
            slot      <= 4'd0;
            op_q      <= OP_START;
            wsh       <= 8'h00;
            rsh       <= 8'h00;
            ack_q     <= 1'b0;
            nack_q    <= 1'b0;
            arb_q     <= 1'b0;
            cmd_ready <= 1'b1;
            done      <= 1'b0;
            rdata     <= 8'h00;
            rx_nack   <= 1'b0;
            arb_lost  <= 1'b0;
            bus_busy  <= 1'b0;
            scl_oe    <= 1'b0;
            sda_oe    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready <= 1'b0;
                        arb_lost  <= 1'b0;
                        arb_q     <= 1'b0;
                        op_q      <= cmd_op;
                        wsh       <= cmd_wdata;
                        ack_q     <= cmd_ack;
                        quarter   <= 2'd0;
                        cnt       <= CNT_LOAD;
                        slot      <= 4'd0;
                        case (cmd_op)
                            OP_START: begin
                                sda_oe <= 1'b0;
                                state  <= ST_START;
                            end
                            OP_STOP: begin
                                scl_oe <= 1'b1;
                                sda_oe <= 1'b1;
                                state  <= ST_STOP;
                            end
                            OP_WRITE: begin
                                scl_oe <= 1'b1;
                                sda_oe <= ~cmd_wdata[7];
                                state  <= ST_SLOT;
                            end
                            default: begin
                                scl_oe <= 1'b1;
                                sda_oe <= 1'b0;
                                state  <= ST_SLOT;
                            end
                        endcase
                    end
                end

                ST_START, ST_STOP, ST_SLOT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (scl_oe || scl_s) begin
                        // Quarter ends; with SCL released it also waits for the line to read high.
                        cnt     <= CNT_LOAD;
                        quarter <= quarter + 2'd1;
                        if (state == ST_START) begin
                            case (quarter)
                                2'd0:    scl_oe <= 1'b0;
                                2'd1:    sda_oe <= 1'b1;
                                2'd2:    scl_oe <= 1'b1;
                                default: state  <= ST_FINISH;
                            endcase
                        end else if (state == ST_STOP) begin
                            case (quarter)
                                2'd1:    scl_oe <= 1'b0;
                                2'd2:    sda_oe <= 1'b0;
                                2'd3:    state  <= ST_FINISH;
                                default: ;
                            endcase
                        end else begin
                            case (quarter)
                                2'd1: scl_oe <= 1'b0;
                                2'd2: begin
                                    if (op_q == OP_WRITE) begin
                                        if (slot == 4'd8)
                                            nack_q <= sda_s;
                                        else if (wsh[7] && !sda_s)
                                            arb_q <= 1'b1;
                                    end else if (slot != 4'd8) begin
                                        rsh <= {rsh[6:0], sda_s};
                                    end
                                end
                                2'd3: begin
                                    if (arb_q) begin
                                        scl_oe <= 1'b0;
                                        sda_oe <= 1'b0;
                                        state  <= ST_FINISH;
                                    end else if (slot == 4'd8) begin
                                        scl_oe <= 1'b1;
                                        state  <= ST_FINISH;
                                    end else begin
                                        slot   <= slot + 4'd1;
                                        scl_oe <= 1'b1;
                                        wsh    <= {wsh[6:0], 1'b0};
                                        if (slot == 4'd7)
                                            sda_oe <= (op_q == OP_READ) ? ~ack_q : 1'b0;
                                        else
                                            sda_oe <= (op_q == OP_WRITE) ? ~wsh[6] : 1'b0;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                end

                ST_FINISH: begin
                    done      <= 1'b1;
                    cmd_ready <= 1'b1;
                    arb_lost  <= arb_q;
                    state     <= ST_IDLE;
                    case (op_q)
                        OP_START: bus_busy <= 1'b1;
                        OP_STOP:  bus_busy <= 1'b0;
                        OP_WRITE: begin
                            if (arb_q)
                                bus_busy <= 1'b0;
                            else
                                rx_nack <= nack_q;
                        end
                        default:  rdata <= rsh;
                    endcase
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hski2c_byte_engine.sv
// Directed bench for hski2c_byte_engine at CLKDIV=3 (quarter = 4 clocks) with ideal pull-ups,
// a pattern-driven slave on SDA, and an optional slave clock stretch.
module tb_hski2c_byte_engine;

    localparam int LIMIT = 2000;
    localparam logic [1:0] OP_START = 2'd0;
    localparam logic [1:0] OP_STOP  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;
    localparam logic [1:0] OP_READ  = 2'd3;

    logic       clk = 1'b0;
    logic       wb_rst_i;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_wdata;
    logic       cmd_ack;
    logic       done;
    logic [7:0] rdata;
    logic       rx_nack;
    logic       arb_lost;
    logic       bus_busy;
    logic       scl_i;
    logic       sda_i;
    logic       scl_oe;
    logic       sda_oe;

    logic       sl_arm;
    logic [8:0] sl_pat;
    logic       sl_sda_low;
    logic       sl_scl_low;
    logic [8:0] mon_sda;
    logic [8:0] mon_oe;

    int n_checks = 0;
    int n_errors = 0;
    int lat;
    int first_sda;
    int first_scl;
    logic saw_done;

    always #5 clk = ~clk;

    assign scl_i = ~scl_oe & ~sl_scl_low;
    assign sda_i = ~sda_oe & ~sl_sda_low;

    hski2c_byte_engine #(.CLKDIV(3), .CNT_W(8)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (wb_rst_i),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_wdata (cmd_wdata),
        .cmd_ack   (cmd_ack),
        .done      (done),
        .rdata     (rdata),
        .rx_nack   (rx_nack),
        .arb_lost  (arb_lost),
        .bus_busy  (bus_busy),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .scl_oe    (scl_oe),
        .sda_oe    (sda_oe)
    );

    // Slave presents the next slot's bit on every SCL falling edge; bit for slot 0 is set on arming.
    always @(negedge scl_i) begin
        if (sl_arm) begin
            sl_pat     = {sl_pat[7:0], 1'b1};
            sl_sda_low = ~sl_pat[8];
        end
    end

    always @(posedge scl_i) begin
        mon_sda = {mon_sda[7:0], sda_i};
        mon_oe  = {mon_oe[7:0], sda_oe};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic arm(input logic [8:0] pat);
        sl_pat     = pat;
        sl_sda_low = ~pat[8];
        sl_arm     = 1'b1;
    endtask

    task automatic disarm();
        sl_arm     = 1'b0;
        sl_sda_low = 1'b0;
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] wd, input logic a);
        int n = 0;
        while (!cmd_ready && n < LIMIT) begin
            @(posedge clk); #1;
            n++;
        end
        mon_sda   = '0;
        mon_oe    = '0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_wdata = wd;
        cmd_ack   = a;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int cycles);
        cycles    = 0;
        first_sda = -1;
        first_scl = -1;
        while (!done && cycles < LIMIT) begin
            @(posedge clk); #1;
            cycles++;
            if (sda_oe && first_sda < 0) first_sda = cycles;
            if (scl_oe && first_scl < 0) first_scl = cycles;
        end
        chk(tag, 32'(done), 32'h1);
    endtask

    initial begin
        wb_rst_i   = 1'b1;
        cmd_valid  = 1'b0;
        cmd_op     = 2'd0;
        cmd_wdata  = 8'h00;
        cmd_ack    = 1'b0;
        sl_arm     = 1'b0;
        sl_pat     = '1;
        sl_sda_low = 1'b0;
        sl_scl_low = 1'b0;
        mon_sda    = '0;
        mon_oe     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", 32'({cmd_ready, done, scl_oe, sda_oe, rx_nack, arb_lost, bus_busy}), 32'h40);
        chk("rst_rdata", 32'(rdata), 32'h00);
        wb_rst_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // START: SDA pulled at Q2 (clock 8), SCL at Q3 (clock 12), done at 4*4+1.
        send(OP_START, 8'h00, 1'b0);
        chk("start_ready_drop", 32'(cmd_ready), 32'h0);
        wait_done("start_done", lat);
        chk("start_lat", lat, 17);
        chk("start_sda_first", first_sda, 8);
        chk("start_scl_first", first_scl, 12);
        chk("start_busy", 32'({bus_busy, cmd_ready}), 32'h3);
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(done), 32'h0);

        // WRITE 0xA5, slave ACKs in slot 8.
        arm(9'h1FE);
        send(OP_WRITE, 8'hA5, 1'b0);
        wait_done("wr_ack_done", lat);
        disarm();
        chk("wr_ack_lat", lat, 145);
        chk("wr_ack_bits", 32'(mon_sda), 32'h14A);
        chk("wr_ack_nack", 32'(rx_nack), 32'h0);

        // WRITE 0xA5, slave NACKs.
        arm(9'h1FF);
        send(OP_WRITE, 8'hA5, 1'b0);
        wait_done("wr_nack_done", lat);
        disarm();
        chk("wr_nack_bits", 32'(mon_sda), 32'h14B);
        chk("wr_nack_nack", 32'(rx_nack), 32'h1);

        // READ 0x3C, master sends NACK (SDA released in slot 8).
        arm({8'h3C, 1'b1});
        send(OP_READ, 8'h00, 1'b1);
        wait_done("rd_nack_done", lat);
        disarm();
        chk("rd_nack_lat", lat, 145);
        chk("rd_nack_rdata", 32'(rdata), 32'h3C);
        chk("rd_nack_oe", 32'(mon_oe), 32'h000);
        chk("rd_nack_bits", 32'(mon_sda), 32'h079);
        chk("rd_rx_nack_held", 32'(rx_nack), 32'h1);

        // READ 0xC3, master ACKs (drives SDA low in slot 8 only).
        arm({8'hC3, 1'b1});
        send(OP_READ, 8'h00, 1'b0);
        wait_done("rd_ack_done", lat);
        disarm();
        chk("rd_ack_rdata", 32'(rdata), 32'hC3);
        chk("rd_ack_oe", 32'(mon_oe), 32'h001);
        chk("rd_ack_bits", 32'(mon_sda), 32'h186);

        // WRITE 0x5A with slave holding SCL 50 clocks from the start of slot 3.
        // Released at slot+50; synchronizer sees it at slot+52, Q2 ends at slot+53 instead of slot+12: +41.
        arm(9'h1FE);
        fork
            begin
                repeat (3) @(negedge scl_i);
                sl_scl_low = 1'b1;
                repeat (50) @(posedge clk);
                #1 sl_scl_low = 1'b0;
            end
        join_none
        send(OP_WRITE, 8'h5A, 1'b0);
        wait_done("stretch_done", lat);
        disarm();
        chk("stretch_lat", lat, 186);
        chk("stretch_bits", 32'(mon_sda), 32'h0B4);
        chk("stretch_nack", 32'(rx_nack), 32'h0);
        chk("rdata_held", 32'(rdata), 32'hC3);

        // WRITE 0xFF, other master pulls SDA low through slot 2 (zero-based): lost after 3 slots.
        arm(9'h1BF);
        send(OP_WRITE, 8'hFF, 1'b0);
        wait_done("arb_done", lat);
        disarm();
        chk("arb_lat", lat, 49);
        chk("arb_flags", 32'({arb_lost, bus_busy, scl_oe, sda_oe}), 32'h8);
        chk("arb_nack_held", 32'(rx_nack), 32'h0);

        send(OP_START, 8'h00, 1'b0);
        chk("arb_clear_on_accept", 32'(arb_lost), 32'h0);
        wait_done("restart_done", lat);
        chk("restart_busy", 32'(bus_busy), 32'h1);

        send(OP_STOP, 8'h00, 1'b0);
        wait_done("stop_done", lat);
        chk("stop_lat", lat, 17);
        chk("stop_lines", 32'({bus_busy, scl_oe, sda_oe}), 32'h0);

        // Reset in slot 8 of an ACKing READ, while both lines are pulled low.
        send(OP_READ, 8'h00, 1'b0);
        repeat (133) @(posedge clk);
        #1;
        chk("pre_rst_lines", 32'({scl_oe, sda_oe}), 32'h3);
        #2 wb_rst_i = 1'b1;
        #1 chk("rst_immediate", 32'({scl_oe, sda_oe, done, cmd_ready}), 32'h1);
        saw_done = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        wb_rst_i = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        chk("rst_no_done", 32'(saw_done), 32'h0);
        chk("rst_after", 32'({cmd_ready, scl_oe, sda_oe}), 32'h4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
